// File: rtl/gfx_mem_responder.sv
// Memory-side responder for the sprite graphics read port.
// Owns a single-port word memory, serves initiator reads with a registered
// word plus a one-cycle rready strobe, and fits CPU word writes in between
// reads. A starvation counter lets a blocked CPU write pre-empt the next read.
module gfx_mem_responder #(
  parameter int unsigned ADDR_BITS    = 16,
  parameter int unsigned DATA_BITS    = 16,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  // Initiator read port
  input  logic [ADDR_BITS-1:0] memory_address,
  input  logic                 rvalid,
  output logic [DATA_BITS-1:0] memory_data,
  output logic                 rready,
  // CPU write port
  input  logic [ADDR_BITS-1:0] cpu_addr,
  input  logic [DATA_BITS-1:0] cpu_data,
  input  logic                 cpu_wr,
  output logic                 cpu_wr_ack,
  // Status
  output logic                 busy
);

  localparam int unsigned Depth   = 1 << ADDR_BITS;
  localparam int unsigned CntBits = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CntBits-1:0] StarveMax = CntBits'(STARVE_LIMIT);
  localparam logic [CntBits-1:0] CntOne    = CntBits'(1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRead  = 2'd1;
  localparam logic [1:0] StResp  = 2'd2;
  localparam logic [1:0] StWrite = 2'd3;

  logic [1:0]           state_q, state_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [CntBits-1:0]   starve_q, starve_d;
  logic                 write_grant;

  // Word storage; no reset so it maps onto a single-port RAM macro.
  logic [DATA_BITS-1:0] mem [0:Depth-1];

  // A pending write wins when no read competes or when it has waited long enough.
  assign write_grant = cpu_wr && (!rvalid || (starve_q == StarveMax));

  // Next-state and read-address latch.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    case (state_q)
      StIdle: begin
        if (write_grant) begin
          state_d = StWrite;
        end else if (rvalid) begin
          addr_d  = memory_address;
          state_d = StRead;
        end
      end
      StRead:  state_d = StResp;
      StResp:  state_d = StIdle;   // rvalid ignored; next request seen in IDLE
      StWrite: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Starvation counter: counts cycles a CPU write waits, saturating at the limit.
  always_comb begin
    starve_d = starve_q;
    if (!cpu_wr || (state_q == StWrite)) begin
      starve_d = '0;
    end else if (starve_q != StarveMax) begin
      starve_d = starve_q + CntOne;
    end
  end

  // Control state registers with asynchronous reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      starve_q <= starve_d;
    end
  end

  // Memory write port: commits at the end of the WRITE cycle.
  always_ff @(posedge CLK) begin
    if (state_q == StWrite) begin
      mem[cpu_addr] <= cpu_data;
    end
  end

  // Registered read data; holds its value until the next READ.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      memory_data <= '0;
    end else if (state_q == StRead) begin
      memory_data <= mem[addr_q];
    end
  end

  // Strobes decode straight from the state register so reset clears them at once.
  assign rready     = (state_q == StResp);
  assign cpu_wr_ack = (state_q == StWrite);
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_gfx_mem_responder.sv
// Directed bench for gfx_mem_responder: write/read, back-to-back reads,
// starvation pre-emption, async reset mid-read and all-ones addressing.
module tb_gfx_mem_responder;

  logic        CLK = 1'b0;
  logic        RST;
  logic [15:0] memory_address;
  logic        rvalid;
  logic [15:0] memory_data;
  logic        rready;
  logic [15:0] cpu_addr;
  logic [15:0] cpu_data;
  logic        cpu_wr;
  logic        cpu_wr_ack;
  logic        busy;

  int total = 0;
  int bad   = 0;

  gfx_mem_responder #(
    .ADDR_BITS   (16),
    .DATA_BITS   (16),
    .STARVE_LIMIT(8)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .memory_address(memory_address),
    .rvalid        (rvalid),
    .memory_data   (memory_data),
    .rready        (rready),
    .cpu_addr      (cpu_addr),
    .cpu_data      (cpu_data),
    .cpu_wr        (cpu_wr),
    .cpu_wr_ack    (cpu_wr_ack),
    .busy          (busy)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just past the rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic write_word(input logic [15:0] a, input logic [15:0] d, input string tag);
    cpu_addr = a;
    cpu_data = d;
    cpu_wr   = 1'b1;
    tick();
    check({tag, "_ack"}, cpu_wr_ack, 1);
    cpu_wr = 1'b0;
    tick();
    check({tag, "_ack_low"}, cpu_wr_ack, 0);
  endtask

  task automatic read_word(input logic [15:0] a, input logic [15:0] exp, input string tag);
    memory_address = a;
    rvalid         = 1'b1;
    tick();
    check({tag, "_rdy_early"}, rready, 0);
    check({tag, "_busy"}, busy, 1);
    tick();
    check({tag, "_rdy"}, rready, 1);
    check({tag, "_data"}, memory_data, exp);
    rvalid = 1'b0;
    tick();
    check({tag, "_rdy_low"}, rready, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] exp_tab [3];
    int          cyc;
    int          last;
    int          pulses;
    bit          found;

    exp_tab[0] = 16'h1111;
    exp_tab[1] = 16'h2222;
    exp_tab[2] = 16'h3333;

    RST            = 1'b1;
    memory_address = '0;
    rvalid         = 1'b0;
    cpu_addr       = '0;
    cpu_data       = '0;
    cpu_wr         = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_rready", rready, 0);
    check("rst_ack", cpu_wr_ack, 0);
    check("rst_busy", busy, 0);
    check("rst_data", memory_data, 0);
    RST = 1'b0;
    tick();
    check("idle_busy", busy, 0);

    // Write then read back.
    write_word(16'h0012, 16'haa55, "wr12");
    read_word(16'h0012, 16'haa55, "rd12");

    // Preload and back-to-back reads with rvalid held.
    write_word(16'h0010, 16'h1111, "wr10");
    write_word(16'h0011, 16'h2222, "wr11");
    write_word(16'h0012, 16'h3333, "wr12b");
    memory_address = 16'h0010;
    rvalid         = 1'b1;
    cyc  = 0;
    last = 0;
    for (int i = 0; i < 3; i++) begin
      found = 1'b0;
      for (int k = 0; k < 10 && !found; k++) begin
        tick();
        cyc++;
        if (rready) found = 1'b1;
      end
      check("b2b_seen", found, 1);
      check("b2b_data", memory_data, exp_tab[i]);
      if (i == 0) check("b2b_first_lat", cyc, 2);
      else        check("b2b_spacing", cyc - last, 3);
      last           = cyc;
      memory_address = memory_address + 16'h0001;
    end
    rvalid = 1'b0;
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (rready) pulses++;
    end
    check("b2b_no_dup", pulses, 0);

    // Continuous reads with a competing CPU write: read goes first, write
    // pre-empts once the counter saturates (acked on the 10th edge).
    cpu_addr       = 16'h0100;
    cpu_data       = 16'hbeef;
    cpu_wr         = 1'b1;
    memory_address = 16'h0010;
    rvalid         = 1'b1;
    cyc    = 0;
    pulses = 0;
    found  = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      tick();
      cyc++;
      if (rready) begin
        pulses++;
        check("starve_rd_data", memory_data, 16'h1111);
        if (pulses == 1) check("starve_rd_first", cyc, 2);
      end
      if (cpu_wr_ack) found = 1'b1;
    end
    check("starve_ack_seen", found, 1);
    check("starve_ack_cycle", cyc, 10);
    check("starve_reads", pulses, 3);
    cpu_wr = 1'b0;
    rvalid = 1'b0;
    tick();
    check("starve_idle", busy, 0);
    check("starve_ack_low", cpu_wr_ack, 0);
    read_word(16'h0100, 16'hbeef, "rd100");

    // Async reset in the middle of a read.
    write_word(16'h0012, 16'haa55, "wr12c");
    memory_address = 16'h0012;
    rvalid         = 1'b1;
    tick();
    check("mid_busy", busy, 1);
    #2;
    RST = 1'b1;
    #1;
    check("arst_rready", rready, 0);
    check("arst_ack", cpu_wr_ack, 0);
    check("arst_busy", busy, 0);
    check("arst_data", memory_data, 0);
    @(posedge CLK);
    #1;
    rvalid = 1'b0;
    RST    = 1'b0;
    pulses = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (rready) pulses++;
    end
    check("arst_no_resp", pulses, 0);
    read_word(16'h0012, 16'haa55, "rd12_after_rst");

    // Extreme addresses.
    write_word(16'h0000, 16'h1234, "wr0000");
    write_word(16'hffff, 16'h5a5a, "wrffff");
    read_word(16'hffff, 16'h5a5a, "rdffff");
    read_word(16'h0000, 16'h1234, "rd0000");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gfx_mem_responder.md
Name: gfx_mem_responder

Overview:
Memory-side responder for the sprite controller's graphics read port (memory_address / memory_data / rvalid / rready). It owns a single-port word memory (SPRAM-inferable) holding sprite bitmaps. It answers each initiator read with a registered data word and a one-cycle rready strobe. It also accepts CPU word writes at lower priority, with an anti-starvation counter so CPU uploads complete even during continuous sprite fetch.

Parameters:
ADDR_BITS, 16, word address width; memory depth is 2^ADDR_BITS words
DATA_BITS, 16, word width
STARVE_LIMIT, 8, number of cycles a pending CPU write may be blocked before it pre-empts the next read

Ports:
CLK  in  1  system clock, all logic on rising edge
RST  in  1  asynchronous active-high reset
memory_address  in  ADDR_BITS  read word address from initiator, valid while rvalid=1
rvalid  in  1  initiator read request; held with a stable address until rready is seen
memory_data  out  DATA_BITS  read data, valid in the cycle rready=1
rready  out  1  one-cycle strobe: memory_data holds the word for the accepted request
cpu_addr  in  ADDR_BITS  CPU write word address
cpu_data  in  DATA_BITS  CPU write data
cpu_wr  in  1  CPU write request; held with stable addr/data until cpu_wr_ack
cpu_wr_ack  out  1  one-cycle strobe: write committed this cycle
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async, any state): state=IDLE; rready=0, cpu_wr_ack=0, busy=0, memory_data=0, starve_cnt=0, latched address=0. Memory contents are not cleared. Reset mid-READ or mid-RESP drops the transaction with no rready pulse.
- States: IDLE, READ, RESP, WRITE.
- IDLE arbitration, evaluated each cycle:
  - cpu_wr=1 and (rvalid=0 or starve_cnt==STARVE_LIMIT): go to WRITE.
  - Otherwise, if rvalid=1: latch memory_address, go to READ.
  - Otherwise stay in IDLE.
- READ: memory is read at the latched address; data is registered into memory_data at the end of the cycle; go to RESP.
- RESP: rready=1 for exactly this cycle; memory_data holds the word; go to IDLE. rvalid is ignored in RESP. The initiator presents its next address in the following cycle.
- Read latency: rvalid first sampled at edge N gives rready=1 during cycle N+2. Peak throughput is one read per 3 cycles.
- memory_data holds its last value until the next READ; it is not zeroed after RESP.
- WRITE: memory[cpu_addr] <= cpu_data at the end of the cycle; cpu_wr_ack=1 this cycle; starve_cnt cleared; go to IDLE.
- starve_cnt: increments each cycle cpu_wr=1 and state!=WRITE; saturates at STARVE_LIMIT; cleared in WRITE and whenever cpu_wr=0.
- A read to an address written in the immediately preceding WRITE returns the new data (write commits before the next READ cycle).
- Addresses use the full ADDR_BITS range with no wrap or bounds logic. Address all-ones is valid.
- busy = (state != IDLE), registered with state.

Test Plan:
- CPU write cpu_addr=0x0012, cpu_data=0xaa55 with rvalid=0 → cpu_wr_ack pulses 1 cycle after cpu_wr is sampled. Then rvalid=1, memory_address=0x0012 → rready=1 exactly 2 cycles later with memory_data=0xaa55; rready low otherwise.
- Held rvalid with address stepping 0x0010, 0x0011, 0x0012 after each rready (preloaded 0x1111/0x2222/0x3333) → three rready pulses spaced 3 cycles apart with matching data. No duplicate responses.
- rvalid held continuously, cpu_wr=1 (addr 0x0100, data 0xbeef), STARVE_LIMIT=8 → write is deferred until starve_cnt reaches 8, then WRITE pre-empts at the next IDLE. cpu_wr_ack pulses, and a subsequent read of 0x0100 returns 0xbeef.
- cpu_wr and rvalid both asserted in IDLE with starve_cnt=0 → read is served first (rready, correct data); starve_cnt increments while blocked.
- RST asserted during READ → rready, cpu_wr_ack and busy go to 0 asynchronously, and memory_data=0. After release, a new read of 0x0012 still returns 0xaa55 (memory retained).
- Write then read address 0xFFFF with data 0x5a5a → read returns 0x5a5a, and address 0x0000 is unaffected.
